gcd_arbiter: RTL and testbench

Shares one subtractive GCD engine (datapath plus controller) among `N_REQ` requesters. It arbitrates round-robin and latches the winner's operand pair. It then sequences the engine's start/load protocol over the engine's single `data_in` bus and returns the result, tagged with the requester index, on a valid/ready response port. Zero operands bypass the engine, because the subtractive loop would never terminate on them.

---
 rtl/gcd_pkg.sv | 28 ++
 rtl/gcd_rr_arbiter.sv | 43 ++++
 rtl/gcd_arbiter.sv | 173 +++++++++++++++++
 tb/tb_gcd_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// ============================================================================
// Module   : gcd_pkg
// Brief    : Shared types, defaults and helpers for the GCD arbiter slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_LOAD_B = 3'd3,
        ST_WAIT   = 3'd4,
        ST_RESP   = 3'd5
    } gcd_arb_state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int gcd_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gcd_rr_arbiter.sv
// ============================================================================
// Module   : gcd_rr_arbiter
// Brief    : Combinational round-robin pick, searching from last_grant+1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gcd_rr_arbiter
    import gcd_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = gcd_id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req_valid,
    input  logic [ID_W-1:0]  i_last_grant,
    output logic [N_REQ-1:0] o_grant_oh,
    output logic [ID_W-1:0]  o_grant_idx,
    output logic             o_any
);

    always_comb begin
        int pos;
        pos         = 0;
        o_grant_oh  = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        // Nearest candidate after the last winner takes the grant.
        for (int k = 1; k <= N_REQ; k++) begin
            pos = int'(i_last_grant) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (!o_any && i_req_valid[pos]) begin
                o_any           = 1'b1;
                o_grant_oh[pos] = 1'b1;
                o_grant_idx     = ID_W'(pos);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gcd_arbiter.sv
// ============================================================================
// Module   : gcd_arbiter
// Brief    : Shares one subtractive GCD engine among N_REQ requesters.
//            Optional engine watchdog: define GCD_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int WIDTH          = GCD_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*WIDTH-1:0]      req_a,
    input  logic [N_REQ*WIDTH-1:0]      req_b,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        eng_start,
    output logic [WIDTH-1:0]            eng_data_in,
    input  logic                        eng_done,
    input  logic [WIDTH-1:0]            eng_result,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [gcd_id_w(N_REQ)-1:0]  rsp_id,
    output logic [WIDTH-1:0]            rsp_gcd,
    output logic                        rsp_err
);

    localparam int c_ID_W = gcd_id_w(N_REQ);

    gcd_arb_state_t     r_state;
    logic [c_ID_W-1:0]  r_last;
    logic [WIDTH-1:0]   r_op_b;
    logic [N_REQ-1:0]   r_req_ready;
    logic               r_eng_start;
    logic [WIDTH-1:0]   r_eng_data;
    logic               r_rsp_valid;
    logic [c_ID_W-1:0]  r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_gcd;

    logic [N_REQ-1:0]   w_grant_oh;
    logic [c_ID_W-1:0]  w_grant_idx;
    logic               w_any;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES);
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_rsp_err;
`endif

    gcd_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (c_ID_W)
    ) u_rr (
        .i_req_valid  (req_valid),
        .i_last_grant (r_last),
        .o_grant_oh   (w_grant_oh),
        .o_grant_idx  (w_grant_idx),
        .o_any        (w_any)
    );

    assign w_a = req_a[w_grant_idx*WIDTH +: WIDTH];
    assign w_b = req_b[w_grant_idx*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last      <= c_ID_W'(N_REQ - 1);
            r_op_b      <= '0;
            r_req_ready <= '0;
            r_eng_start <= 1'b0;
            r_eng_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_gcd   <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
            r_cnt       <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_req_ready <= '0;
            r_eng_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_req_ready <= w_grant_oh;
                        r_last      <= w_grant_idx;
                        r_rsp_id    <= w_grant_idx;
                        r_op_b      <= w_b;
                        // A zero operand would spin the subtractive loop forever.
                        if ((w_a == '0) || (w_b == '0)) begin
                            r_rsp_gcd   <= w_a | w_b;
                            r_rsp_valid <= 1'b1;
`ifdef GCD_ARB_TIMEOUT_EN
                            r_rsp_err   <= 1'b0;
`endif
                            r_state     <= ST_RESP;
                        end else begin
                            r_eng_start <= 1'b1;
                            r_eng_data  <= w_a;
                            r_state     <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    r_state <= ST_LOAD_A;
                end
                ST_LOAD_A: begin
                    r_eng_data <= r_op_b;
                    r_state    <= ST_LOAD_B;
                end
                ST_LOAD_B: begin
`ifdef GCD_ARB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        r_rsp_gcd   <= eng_result;
                        r_rsp_valid <= 1'b1;
`ifdef GCD_ARB_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_state     <= ST_RESP;
                    end
`ifdef GCD_ARB_TIMEOUT_EN
                    else if (r_cnt == c_CNT_MAX) begin
                        r_rsp_gcd   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign eng_start   = r_eng_start;
    assign eng_data_in = r_eng_data;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_gcd     = r_rsp_gcd;

`ifdef GCD_ARB_TIMEOUT_EN
    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gcd_arbiter.sv
// ============================================================================
// Module   : tb_gcd_arbiter
// Brief    : Self-checking bench for gcd_arbiter with a behavioural engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gcd_arbiter;
    import gcd_pkg::*;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int TO  = 16;
    localparam int IDW = gcd_id_w(N);

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*W-1:0]    req_a;
    logic [N*W-1:0]    req_b;
    logic [N-1:0]      req_ready;
    logic              eng_start;
    logic [W-1:0]      eng_data_in;
    logic              eng_done;
    logic [W-1:0]      eng_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_gcd;
    logic              rsp_err;

    int checks   = 0;
    int failures = 0;

    gcd_arbiter #(
        .N_REQ          (N),
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .eng_start   (eng_start),
        .eng_data_in (eng_data_in),
        .eng_done    (eng_done),
        .eng_result  (eng_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_gcd     (rsp_gcd),
        .rsp_err     (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural subtractive engine: start, load A, load B, then iterate.
    logic [1:0]   e_phase;
    logic [W-1:0] e_a;
    logic [W-1:0] e_b;
    logic         e_hang;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_phase  <= 2'd0;
            e_a      <= '0;
            e_b      <= '0;
            eng_done <= 1'b0;
        end else if (eng_start) begin
            eng_done <= 1'b0;
            e_phase  <= 2'd1;
        end else begin
            case (e_phase)
                2'd1: begin e_a <= eng_data_in; e_phase <= 2'd2; end
                2'd2: begin e_b <= eng_data_in; e_phase <= 2'd3; end
                2'd3: begin
                    if (!e_hang) begin
                        if (e_a == e_b) begin
                            eng_done <= 1'b1;
                            e_phase  <= 2'd0;
                        end else if (e_a > e_b) begin
                            e_a <= e_a - e_b;
                        end else begin
                            e_b <= e_b - e_a;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
    assign eng_result = e_a;

    function automatic longint gcd_ref(input longint a_in, input longint b_in);
        longint a, b, t;
        a = a_in;
        b = b_in;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Model of the transaction in flight, advanced once per cycle.
    logic [N-1:0]   p_valid;
    logic [N*W-1:0] p_a, p_b;
    logic           p_rsp_valid, p_rsp_ready, p_rsp_err;
    logic [IDW-1:0] p_rsp_id;
    logic [W-1:0]   p_rsp_gcd;
    bit             m_busy, m_byp, m_due;
    int             m_last, m_id, m_gcnt;
    longint         m_a, m_b, m_gcd, m_err;
    int             log_id[$];
    int             log_gcd[$];
    int             log_err[$];

    initial begin
        p_valid = '0; p_a = '0; p_b = '0;
        p_rsp_valid = 1'b0; p_rsp_ready = 1'b0; p_rsp_err = 1'b0;
        p_rsp_id = '0; p_rsp_gcd = '0;
        m_busy = 0; m_byp = 0; m_due = 0;
        m_last = N - 1; m_id = 0; m_gcnt = 0;
        m_a = 0; m_b = 0; m_gcd = 0; m_err = 0;
    end

    always @(negedge clk) begin
        int           idx;
        logic [N-1:0] exp_rdy;
        bit           exp_v;
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_eng_start", eng_start, 0);
            chk("rst_eng_data_in", eng_data_in, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_gcd", rsp_gcd, 0);
            chk("rst_rsp_err", rsp_err, 0);
            m_busy = 0;
            m_due  = 0;
            m_last = N - 1;
        end else begin
            exp_rdy = '0;
            if (m_busy) begin
                if (p_rsp_valid && p_rsp_ready) begin
                    log_id.push_back(int'(p_rsp_id));
                    log_gcd.push_back(int'(p_rsp_gcd));
                    log_err.push_back(int'(p_rsp_err));
                    m_busy = 0;
                end
            end else if (p_valid != '0) begin
                idx          = rr_pick(p_valid, m_last);
                exp_rdy[idx] = 1'b1;
                m_last       = idx;
                m_id         = idx;
                m_a          = longint'(p_a[idx*W +: W]);
                m_b          = longint'(p_b[idx*W +: W]);
                m_byp        = (m_a == 0) || (m_b == 0);
                m_gcd        = gcd_ref(m_a, m_b);
                m_err        = 0;
                m_due        = 0;
                m_gcnt       = 0;
                m_busy       = 1;
            end
            chk("req_ready", req_ready, exp_rdy);
            if (m_busy) begin
                m_gcnt++;
                exp_v = m_byp || m_due;
                chk("rsp_valid", rsp_valid, exp_v);
                if (exp_v) begin
                    chk("rsp_id", rsp_id, m_id);
                    chk("rsp_gcd", rsp_gcd, m_gcd);
                    chk("rsp_err", rsp_err, m_err);
                end
                chk("eng_start", eng_start, (!m_byp && m_gcnt == 1) ? 1 : 0);
                if (!m_byp && !exp_v) begin
                    chk("eng_data_in", eng_data_in, (m_gcnt <= 2) ? m_a : m_b);
                end
                if (!m_byp && !m_due) begin
                    if (m_gcnt >= 4 && eng_done) begin
                        m_due = 1;
                    end
`ifdef GCD_ARB_TIMEOUT_EN
                    else if (m_gcnt == 4 + TO) begin
                        m_due = 1;
                        m_gcd = 0;
                        m_err = 1;
                    end
`endif
                end
            end else begin
                chk("rsp_valid_idle", rsp_valid, 0);
                chk("eng_start_idle", eng_start, 0);
            end
        end
        p_valid     = req_valid;
        p_a         = req_a;
        p_b         = req_b;
        p_rsp_valid = rsp_valid;
        p_rsp_ready = rsp_ready;
        p_rsp_id    = rsp_id;
        p_rsp_gcd   = rsp_gcd;
        p_rsp_err   = rsp_err;
    end

    // Requesters withdraw once they see their accept pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) req_valid[i] = 1'b0;
        end
    endtask

    task automatic request(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
        req_valid[i]    = 1'b1;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (log_id.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk(name, (log_id.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic expect_rsp(input int k, input int id, input int g, input int e, input string name);
        if (log_id.size() > k) begin
            chk({name, "_id"}, log_id[k], id);
            chk({name, "_gcd"}, log_gcd[k], g);
            chk({name, "_err"}, log_err[k], e);
        end else begin
            chk({name, "_present"}, 0, 1);
        end
    endtask

    initial begin
        int t2_gcd[4];
        int n0;
        int c;
        t2_gcd = '{6, 7, 1, 25};
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        e_hang = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Four simultaneous requests straight out of reset.
        request(0, 48, 18);
        request(1, 35, 14);
        request(2, 17, 5);
        request(3, 100, 75);
        wait_log(4, 400, "t2_wait");
        for (int i = 0; i < 4; i++) expect_rsp(i, i, t2_gcd[i], 0, "t2_rsp");

        request(0, 143, 78);
        wait_log(5, 400, "t1_wait");
        expect_rsp(4, 0, 13, 0, "t1_rsp");

        request(2, 0, 21);
        wait_log(6, 50, "byp_wait");
        expect_rsp(5, 2, 21, 0, "byp_rsp");
        request(2, 0, 0);
        wait_log(7, 50, "byp0_wait");
        expect_rsp(6, 2, 0, 0, "byp0_rsp");

        // Backpressure with a second requester queued behind the response.
        rsp_ready = 1'b0;
        request(0, 48, 36);
        c = 0;
        while (!rsp_valid && c < 200) begin
            tick();
            c++;
        end
        chk("bp_valid_seen", rsp_valid, 1);
        request(1, 9, 6);
        repeat (10) tick();
        chk("bp_gcd_held", rsp_gcd, 12);
        chk("bp_req1_waiting", req_valid[1], 1);
        rsp_ready = 1'b1;
        wait_log(9, 200, "bp_wait");
        expect_rsp(7, 0, 12, 0, "bp_rsp0");
        expect_rsp(8, 1, 3, 0, "bp_rsp1");

        // Abort a transaction stuck in WAIT.
        e_hang = 1'b1;
        request(3, 30, 12);
        repeat (10) tick();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_req_ready", req_ready, 0);
        chk("abort_eng_start", eng_start, 0);
        chk("abort_eng_data_in", eng_data_in, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_id", rsp_id, 0);
        chk("abort_rsp_gcd", rsp_gcd, 0);
        chk("abort_rsp_err", rsp_err, 0);
        req_valid = '0;
        e_hang = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n0 = log_id.size();
        chk("abort_no_rsp", n0, 9);
        request(3, 30, 12);
        wait_log(n0 + 1, 300, "post_abort_wait");
        expect_rsp(n0, 3, 6, 0, "post_abort_rsp");

`ifdef GCD_ARB_TIMEOUT_EN
        e_hang = 1'b1;
        n0 = log_id.size();
        request(1, 10, 4);
        wait_log(n0 + 1, 100, "to_wait");
        expect_rsp(n0, 1, 0, 1, "to_rsp");
        e_hang = 1'b0;
        n0 = log_id.size();
        request(2, 10, 4);
        wait_log(n0 + 1, 100, "after_to_wait");
        expect_rsp(n0, 2, 2, 0, "after_to_rsp");
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
